// File: rtl/blackjack_table_fsm.sv
// rtl/blackjack_table_fsm.sv - blackjack round sequencer: deal, player turn, dealer draw, winner
//
// Purpose: consumes cards from a 1..10 card source over a req/valid handshake,
// deals two cards each to player and dealer, runs the player hit/stand turn and
// the dealer draw-to-threshold turn, then latches the round result.
//
// Ports:
//   clock    in   1  system clock
//   reset    in   1  synchronous, active-high
//   start    in   1  begin a new round (honoured only when not busy)
//   hit      in   1  player requests a card (honoured only in PTURN)
//   stand    in   1  player stands (honoured only in PTURN, beats hit)
//   card_in  in   5  card value from the source, legal 1..10
//   card_vld in   1  card_in is valid this cycle
//   card_req out  1  registered request for one card
//   phand    out  5  player hand sum
//   dhand    out  5  dealer hand sum
//   pcard    out  5  last card given to the player
//   dcard    out  5  last card given to the dealer
//   winner   out  2  00 in play, 01 player, 10 dealer, 11 push
//   busy     out  1  high outside IDLE and DONE

module blackjack_table_fsm #(
    parameter int DEALER_STAND = 17,
    parameter int BUST_LIMIT   = 21
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       hit,
    input  logic       stand,
    input  logic [4:0] card_in,
    input  logic       card_vld,
    output logic       card_req,
    output logic [4:0] phand,
    output logic [4:0] dhand,
    output logic [4:0] pcard,
    output logic [4:0] dcard,
    output logic [1:0] winner,
    output logic       busy
);

    localparam logic [4:0] STAND_V = 5'(DEALER_STAND);
    localparam logic [4:0] BUST_V  = 5'(BUST_LIMIT);

    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_PLAYER = 2'b01;
    localparam logic [1:0] WIN_DEALER = 2'b10;
    localparam logic [1:0] WIN_PUSH   = 2'b11;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        DP1   = 4'd1,
        DD1   = 4'd2,
        DP2   = 4'd3,
        DD2   = 4'd4,
        PTURN = 4'd5,
        PDRAW = 4'd6,
        DTURN = 4'd7,
        DDRAW = 4'd8,
        DONE  = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic       card_req_q, card_req_d;
    logic [4:0] phand_q, phand_d;
    logic [4:0] dhand_q, dhand_d;
    logic [4:0] pcard_q, pcard_d;
    logic [4:0] dcard_q, dcard_d;
    logic [1:0] winner_q, winner_d;

    logic       is_draw;
    logic       card_ok;
    logic       accept;
    logic [4:0] p_sum;
    logic [4:0] d_sum;

    // Sums never exceed 30 (hit allowed only up to 20, card max 10), so 5 bits hold them.
    assign p_sum   = phand_q + card_in;
    assign d_sum   = dhand_q + card_in;
    assign card_ok = (card_in >= 5'd1) && (card_in <= 5'd10);
    // Acceptance keys off the registered request, so a valid that arrives
    // while the request is still low (including the entry cycle) is dropped.
    assign accept  = card_req_q && card_vld && card_ok;

    always_comb begin
        is_draw = 1'b0;
        case (state_q)
            DP1, DD1, DP2, DD2, PDRAW, DDRAW: is_draw = 1'b1;
            default:                          is_draw = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phand_d    = phand_q;
        dhand_d    = dhand_q;
        pcard_d    = pcard_q;
        dcard_d    = dcard_q;
        winner_d   = winner_q;
        // Request rises the cycle after entering a draw state and falls on the accept edge.
        card_req_d = is_draw && !accept;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    phand_d  = 5'd0;
                    dhand_d  = 5'd0;
                    pcard_d  = 5'd0;
                    dcard_d  = 5'd0;
                    winner_d = WIN_NONE;
                    state_d  = DP1;
                end
            end
            DP1: begin
                if (accept) begin
                    phand_d = p_sum;
                    pcard_d = card_in;
                    state_d = DD1;
                end
            end
            DD1: begin
                if (accept) begin
                    dhand_d = d_sum;
                    dcard_d = card_in;
                    state_d = DP2;
                end
            end
            DP2: begin
                if (accept) begin
                    phand_d = p_sum;
                    pcard_d = card_in;
                    state_d = DD2;
                end
            end
            DD2: begin
                if (accept) begin
                    dhand_d = d_sum;
                    dcard_d = card_in;
                    state_d = PTURN;
                end
            end
            PTURN: begin
                // A hand of exactly 21 stands automatically; stand beats hit.
                if (phand_q == BUST_V) begin
                    state_d = DTURN;
                end else if (stand) begin
                    state_d = DTURN;
                end else if (hit) begin
                    state_d = PDRAW;
                end
            end
            PDRAW: begin
                if (accept) begin
                    phand_d = p_sum;
                    pcard_d = card_in;
                    if (p_sum > BUST_V) begin
                        winner_d = WIN_DEALER;
                        state_d  = DONE;
                    end else begin
                        state_d = PTURN;
                    end
                end
            end
            DTURN: begin
                if (dhand_q >= STAND_V) begin
                    state_d = DONE;
                    if (dhand_q > BUST_V) begin
                        winner_d = WIN_PLAYER;
                    end else if (phand_q > dhand_q) begin
                        winner_d = WIN_PLAYER;
                    end else if (phand_q < dhand_q) begin
                        winner_d = WIN_DEALER;
                    end else begin
                        winner_d = WIN_PUSH;
                    end
                end else begin
                    state_d = DDRAW;
                end
            end
            DDRAW: begin
                if (accept) begin
                    dhand_d = d_sum;
                    dcard_d = card_in;
                    state_d = DTURN;
                end
            end
            default: begin
                state_d    = IDLE;
                card_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            card_req_q <= 1'b0;
            phand_q    <= 5'd0;
            dhand_q    <= 5'd0;
            pcard_q    <= 5'd0;
            dcard_q    <= 5'd0;
            winner_q   <= WIN_NONE;
        end else begin
            state_q    <= state_d;
            card_req_q <= card_req_d;
            phand_q    <= phand_d;
            dhand_q    <= dhand_d;
            pcard_q    <= pcard_d;
            dcard_q    <= dcard_d;
            winner_q   <= winner_d;
        end
    end

    assign card_req = card_req_q;
    assign phand    = phand_q;
    assign dhand    = dhand_q;
    assign pcard    = pcard_q;
    assign dcard    = dcard_q;
    assign winner   = winner_q;
    assign busy     = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_blackjack_table_fsm.sv
// tb/tb_blackjack_table_fsm.sv - directed self-checking bench for blackjack_table_fsm

module tb_blackjack_table_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       hit;
    logic       stand;
    logic [4:0] card_in;
    logic       card_vld;
    logic       card_req;
    logic [4:0] phand;
    logic [4:0] dhand;
    logic [4:0] pcard;
    logic [4:0] dcard;
    logic [1:0] winner;
    logic       busy;

    int vectors = 0;
    int errors  = 0;
    logic saw;

    blackjack_table_fsm dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .hit      (hit),
        .stand    (stand),
        .card_in  (card_in),
        .card_vld (card_vld),
        .card_req (card_req),
        .phand    (phand),
        .dhand    (dhand),
        .pcard    (pcard),
        .dcard    (dcard),
        .winner   (winner),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (card_req !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("req_timeout", {7'd0, n < 100}, 8'd1);
    endtask

    task automatic give_card(input logic [4:0] v);
        wait_req();
        @(negedge clock);
        card_vld = 1'b1;
        card_in  = v;
        @(negedge clock);
        card_vld = 1'b0;
        card_in  = 5'd0;
    endtask

    task automatic wait_done(output logic saw_req);
        int n = 0;
        saw_req = 1'b0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clock);
            if (card_req === 1'b1) saw_req = 1'b1;
            n++;
        end
        check("done_timeout", {7'd0, n < 100}, 8'd1);
    endtask

    task automatic pulse(input logic s, input logic h, input logic t);
        start = s;
        hit   = h;
        stand = t;
        @(negedge clock);
        start = 1'b0;
        hit   = 1'b0;
        stand = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req"},    {7'd0, card_req}, 8'd0);
        check({tag, "_phand"},  {3'd0, phand},    8'd0);
        check({tag, "_dhand"},  {3'd0, dhand},    8'd0);
        check({tag, "_pcard"},  {3'd0, pcard},    8'd0);
        check({tag, "_dcard"},  {3'd0, dcard},    8'd0);
        check({tag, "_winner"}, {6'd0, winner},   8'd0);
        check({tag, "_busy"},   {7'd0, busy},     8'd0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        hit      = 1'b0;
        stand    = 1'b0;
        card_in  = 5'd0;
        card_vld = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_zero("reset");

        // Round 1: 10,7,9,8 -> 19 vs 15; stand; dealer draws 5 -> 20, dealer wins
        pulse(1'b1, 1'b0, 1'b0);
        check("r1_busy", {7'd0, busy}, 8'd1);
        give_card(5'd10);
        give_card(5'd7);
        give_card(5'd9);
        give_card(5'd8);
        check("r1_phand", {3'd0, phand}, 8'd19);
        check("r1_dhand", {3'd0, dhand}, 8'd15);
        check("r1_pcard", {3'd0, pcard}, 8'd9);
        check("r1_dcard", {3'd0, dcard}, 8'd8);
        check("r1_req_pturn", {7'd0, card_req}, 8'd0);
        pulse(1'b0, 1'b0, 1'b1);
        give_card(5'd5);
        wait_done(saw);
        check("r1_dhand_end", {3'd0, dhand}, 8'd20);
        check("r1_winner", {6'd0, winner}, 8'd2);

        // Round 2: 10,6,8,10 -> 18 vs 16; hit 5 -> 23 bust, dealer does not draw
        pulse(1'b1, 1'b0, 1'b0);
        check("r2_winner_clr", {6'd0, winner}, 8'd0);
        give_card(5'd10);
        give_card(5'd6);
        give_card(5'd8);
        give_card(5'd10);
        pulse(1'b0, 1'b1, 1'b0);
        give_card(5'd5);
        check("r2_busy", {7'd0, busy}, 8'd0);
        check("r2_phand", {3'd0, phand}, 8'd23);
        check("r2_dhand", {3'd0, dhand}, 8'd16);
        check("r2_winner", {6'd0, winner}, 8'd2);
        saw = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (card_req === 1'b1) saw = 1'b1;
        end
        check("r2_no_req", {7'd0, saw}, 8'd0);

        // Round 3: 10,10,7,6 -> 17 vs 16; stand; dealer draws 8 -> 24 bust, player wins
        pulse(1'b1, 1'b0, 1'b0);
        give_card(5'd10);
        give_card(5'd10);
        give_card(5'd7);
        give_card(5'd6);
        pulse(1'b0, 1'b0, 1'b1);
        give_card(5'd8);
        wait_done(saw);
        check("r3_dhand", {3'd0, dhand}, 8'd24);
        check("r3_winner", {6'd0, winner}, 8'd1);

        // Round 4: 10,10,8,8 -> 18 vs 18; stand; dealer stands, push
        pulse(1'b1, 1'b0, 1'b0);
        give_card(5'd10);
        give_card(5'd10);
        give_card(5'd8);
        give_card(5'd8);
        pulse(1'b0, 1'b0, 1'b1);
        wait_done(saw);
        check("r4_no_draw", {7'd0, saw}, 8'd0);
        check("r4_dhand", {3'd0, dhand}, 8'd18);
        check("r4_winner", {6'd0, winner}, 8'd3);

        // Round 5: illegal cards, stray valid, start while busy, hit+stand together
        pulse(1'b1, 1'b0, 1'b0);
        wait_req();
        @(negedge clock);
        card_vld = 1'b1;
        card_in  = 5'd0;
        @(negedge clock);
        check("hs_zero_req", {7'd0, card_req}, 8'd1);
        check("hs_zero_phand", {3'd0, phand}, 8'd0);
        card_in = 5'd11;
        @(negedge clock);
        check("hs_11_req", {7'd0, card_req}, 8'd1);
        check("hs_11_pcard", {3'd0, pcard}, 8'd0);
        card_in = 5'd4;
        @(negedge clock);
        card_vld = 1'b0;
        card_in  = 5'd0;
        check("hs_4_req", {7'd0, card_req}, 8'd0);
        check("hs_4_phand", {3'd0, phand}, 8'd4);
        check("hs_4_pcard", {3'd0, pcard}, 8'd4);
        card_vld = 1'b1;
        card_in  = 5'd7;
        @(negedge clock);
        card_vld = 1'b0;
        card_in  = 5'd0;
        check("stray_dhand", {3'd0, dhand}, 8'd0);
        check("stray_dcard", {3'd0, dcard}, 8'd0);
        check("stray_req", {7'd0, card_req}, 8'd1);
        pulse(1'b1, 1'b0, 1'b0);
        check("busy_start_dhand", {3'd0, dhand}, 8'd0);
        check("busy_start_phand", {3'd0, phand}, 8'd4);
        check("busy_start_req", {7'd0, card_req}, 8'd1);
        give_card(5'd10);
        give_card(5'd7);
        give_card(5'd5);
        check("r5_phand", {3'd0, phand}, 8'd11);
        check("r5_dhand", {3'd0, dhand}, 8'd15);
        pulse(1'b0, 1'b1, 1'b1);
        give_card(5'd3);
        wait_done(saw);
        check("both_dhand", {3'd0, dhand}, 8'd18);
        check("both_pcard", {3'd0, pcard}, 8'd7);
        check("both_winner", {6'd0, winner}, 8'd2);

        // Round 6: hit to exactly 21 stands automatically; dealer draws 10 -> 17
        pulse(1'b1, 1'b0, 1'b0);
        give_card(5'd10);
        give_card(5'd2);
        give_card(5'd10);
        give_card(5'd5);
        pulse(1'b0, 1'b1, 1'b0);
        give_card(5'd1);
        check("r6_phand", {3'd0, phand}, 8'd21);
        give_card(5'd10);
        wait_done(saw);
        check("r6_dhand", {3'd0, dhand}, 8'd17);
        check("r6_winner", {6'd0, winner}, 8'd1);

        // Round 7: reset while PDRAW is requesting a card
        pulse(1'b1, 1'b0, 1'b0);
        give_card(5'd2);
        give_card(5'd3);
        give_card(5'd4);
        give_card(5'd5);
        pulse(1'b0, 1'b1, 1'b0);
        wait_req();
        check("pdraw_req", {7'd0, card_req}, 8'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_zero("midreset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
